// File: rtl/level_seq_pkg.sv
// rtl/level_seq_pkg.sv - shared state encoding, banner colours and led field positions for level_sequencer
package level_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD        = 3'd1,
        ST_PLAY        = 3'd2,
        ST_WIN_BANNER  = 3'd3,
        ST_LOSE_BANNER = 3'd4,
        ST_VICTORY     = 3'd5,
        ST_GAME_OVER   = 3'd6
    } level_seq_state_t;

    // Colours packed as {red, green, blue}, one nibble each.
    localparam logic [11:0] TITLE_RGB = 12'h00F;
    localparam logic [11:0] WIN_RGB   = 12'h0F0;
    localparam logic [11:0] LOSE_RGB  = 12'hF00;

    localparam int LED_LEVEL_LSB = 0;
    localparam int LED_LIVES_LSB = 4;
    localparam int LED_VICTORY   = 8;
    localparam int LED_GAME_OVER = 9;

endpackage

// File: rtl/button_edge_sync.sv
// rtl/button_edge_sync.sv - two-flop synchronizer plus rising-edge detector for a raw push button
module button_edge_sync (
    input  logic vga_clock,
    input  logic reset,
    input  logic button,
    output logic pulse
);

    logic sync_0;
    logic sync_1;
    logic sync_prev;

    // Resynchronize the button and remember the previous synchronized level.
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            sync_0    <= 1'b0;
            sync_1    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_0    <= button;
            sync_1    <= sync_0;
            sync_prev <= sync_1;
        end
    end

    assign pulse = sync_1 & ~sync_prev;

endmodule

// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - game flow controller owning level resets and VGA colour mux; LEVEL_SEQ_LIVES_EN enables the lives counter
module level_sequencer
    import level_seq_pkg::*;
#(
    parameter int NUM_LEVELS    = 3,
    parameter int LIVES         = 3,
    parameter int BANNER_CYCLES = 50_000_000,
    parameter int ARM_CYCLES    = 4
) (
    input  logic                    vga_clock,
    input  logic                    reset,
    input  logic                    start_button,
    input  logic                    display_enable,
    input  logic [NUM_LEVELS-1:0]   level_win,
    input  logic [NUM_LEVELS-1:0]   level_lose,
    input  logic [NUM_LEVELS*4-1:0] level_red,
    input  logic [NUM_LEVELS*4-1:0] level_green,
    input  logic [NUM_LEVELS*4-1:0] level_blue,
    output logic [NUM_LEVELS-1:0]   level_reset,
    output logic [3:0]              vga_red,
    output logic [3:0]              vga_green,
    output logic [3:0]              vga_blue,
    output logic [3:0]              current_level,
    output logic [9:0]              leds
);

    localparam int BANNER_W = $clog2(BANNER_CYCLES);
    localparam int ARM_W    = $clog2(ARM_CYCLES + 1);
    localparam logic [BANNER_W-1:0] BANNER_LOAD = BANNER_W'(BANNER_CYCLES - 1);
    localparam logic [ARM_W-1:0]    ARM_LOAD    = ARM_W'(ARM_CYCLES);
    localparam logic [3:0]          LAST_LEVEL  = 4'(NUM_LEVELS - 1);

    level_seq_state_t state;
    level_seq_state_t next_state;

    logic                start_pulse;
    logic                load_phase;
    logic [ARM_W-1:0]    arm_count;
    logic [BANNER_W-1:0] banner_count;
    logic                win_sel;
    logic                lose_sel;
    logic                out_of_lives;
    logic [3:0]          lives_field;
    logic [11:0]         level_rgb;
    logic [11:0]         mux_rgb;

    button_edge_sync u_start_sync (
        .vga_clock (vga_clock),
        .reset     (reset),
        .button    (start_button),
        .pulse     (start_pulse)
    );

`ifdef LEVEL_SEQ_LIVES_EN
    logic [3:0] lives;

    // Lives refill whenever the game returns to the title and drop by one on each lose banner exit.
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            lives <= 4'(LIVES);
        end else if (next_state == ST_IDLE) begin
            lives <= 4'(LIVES);
        end else if (state == ST_LOSE_BANNER && banner_count == '0 && lives != 4'd0) begin
            lives <= lives - 4'd1;
        end
    end

    assign out_of_lives = (lives <= 4'd1);
    assign lives_field  = lives;
`else
    assign out_of_lives = 1'b1;
    assign lives_field  = 4'd0;
`endif

    // State register.
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Level index, two-cycle load phase, arm and banner timers.
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            current_level <= 4'd0;
            load_phase    <= 1'b0;
            arm_count     <= '0;
            banner_count  <= '0;
        end else begin
            load_phase <= (state == ST_LOAD) && !load_phase;

            if (state != ST_PLAY) begin
                arm_count <= ARM_LOAD;
            end else if (arm_count != '0) begin
                arm_count <= arm_count - 1'b1;
            end

            if (state != ST_WIN_BANNER && state != ST_LOSE_BANNER) begin
                banner_count <= BANNER_LOAD;
            end else if (banner_count != '0) begin
                banner_count <= banner_count - 1'b1;
            end

            if (next_state == ST_IDLE) begin
                current_level <= 4'd0;
            end else if (state == ST_WIN_BANNER && next_state == ST_LOAD) begin
                current_level <= current_level + 4'd1;
            end
        end
    end

    // Next-state logic; only the selected level's flags matter and win beats lose.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:        if (start_pulse) next_state = ST_LOAD;
            ST_LOAD:        if (load_phase) next_state = ST_PLAY;
            ST_PLAY: begin
                if (arm_count == '0) begin
                    if (win_sel) begin
                        next_state = ST_WIN_BANNER;
                    end else if (lose_sel) begin
                        next_state = ST_LOSE_BANNER;
                    end
                end
            end
            ST_WIN_BANNER: begin
                if (banner_count == '0) begin
                    next_state = (current_level == LAST_LEVEL) ? ST_VICTORY : ST_LOAD;
                end
            end
            ST_LOSE_BANNER: begin
                if (banner_count == '0) begin
                    next_state = out_of_lives ? ST_GAME_OVER : ST_LOAD;
                end
            end
            ST_VICTORY,
            ST_GAME_OVER:   if (start_pulse) next_state = ST_IDLE;
            default:        next_state = ST_IDLE;
        endcase
    end

    // Outputs: level select, level resets, colour mux and status leds, all from registered state.
    always_comb begin
        level_reset = '0;
        win_sel     = 1'b0;
        lose_sel    = 1'b0;
        level_rgb   = 12'h000;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (current_level == 4'(i)) begin
                win_sel   = level_win[i];
                lose_sel  = level_lose[i];
                level_rgb = {level_red[i*4 +: 4], level_green[i*4 +: 4], level_blue[i*4 +: 4]};
                if (state == ST_PLAY) begin
                    level_reset[i] = 1'b1;
                end
            end
        end

        case (state)
            ST_PLAY:                      mux_rgb = level_rgb;
            ST_IDLE:                      mux_rgb = TITLE_RGB;
            ST_WIN_BANNER, ST_VICTORY:    mux_rgb = WIN_RGB;
            ST_LOSE_BANNER, ST_GAME_OVER: mux_rgb = LOSE_RGB;
            default:                      mux_rgb = 12'h000;
        endcase
        if (!display_enable) begin
            mux_rgb = 12'h000;
        end
        {vga_red, vga_green, vga_blue} = mux_rgb;

        leds                        = '0;
        leds[LED_LEVEL_LSB +: 4]    = current_level;
        leds[LED_LIVES_LSB +: 4]    = lives_field;
        leds[LED_VICTORY]           = (state == ST_VICTORY);
        leds[LED_GAME_OVER]         = (state == ST_GAME_OVER);
    end

endmodule

// File: tb/tb_level_sequencer.sv
// tb/tb_level_sequencer.sv - directed scoreboard bench for level_sequencer
module tb_level_sequencer;

    localparam int NL  = 3;
    localparam int NLV = 3;
    localparam int BC  = 8;
    localparam int AC  = 4;

    localparam int SEL_LRST = 0;
    localparam int SEL_LVL  = 1;
    localparam int SEL_LEDS = 2;
    localparam int SEL_RGB  = 3;

`ifdef LEVEL_SEQ_LIVES_EN
    localparam logic [3:0] LF = 4'(NLV);
`else
    localparam logic [3:0] LF = 4'd0;
`endif

    logic              vga_clock = 1'b0;
    logic              reset;
    logic              start_button;
    logic              display_enable;
    logic [NL-1:0]     level_win;
    logic [NL-1:0]     level_lose;
    logic [NL*4-1:0]   level_red   = 12'hCBA;
    logic [NL*4-1:0]   level_green = 12'h321;
    logic [NL*4-1:0]   level_blue  = 12'h654;
    logic [NL-1:0]     level_reset;
    logic [3:0]        vga_red;
    logic [3:0]        vga_green;
    logic [3:0]        vga_blue;
    logic [3:0]        current_level;
    logic [9:0]        leds;

    level_sequencer #(
        .NUM_LEVELS    (NL),
        .LIVES         (NLV),
        .BANNER_CYCLES (BC),
        .ARM_CYCLES    (AC)
    ) dut (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .start_button   (start_button),
        .display_enable (display_enable),
        .level_win      (level_win),
        .level_lose     (level_lose),
        .level_red      (level_red),
        .level_green    (level_green),
        .level_blue     (level_blue),
        .level_reset    (level_reset),
        .vga_red        (vga_red),
        .vga_green      (vga_green),
        .vga_blue       (vga_blue),
        .current_level  (current_level),
        .leds           (leds)
    );

    always #5 vga_clock = ~vga_clock;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic expect_out(input int sel, input string tag, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_LRST: return 32'(level_reset);
            SEL_LVL:  return 32'(current_level);
            SEL_LEDS: return 32'(leds);
            default:  return 32'({vga_red, vga_green, vga_blue});
        endcase
    endfunction

    function automatic logic [31:0] leds_of(input logic go, input logic vic,
                                            input logic [3:0] lives, input logic [3:0] lvl);
        return 32'({go, vic, lives, lvl});
    endfunction

    task automatic score();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            compared++;
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge vga_clock);
            #1;
        end
    endtask

    task automatic press_start();
        start_button = 1'b1;
        step(3);
        start_button = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        start_button   = 1'b0;
        display_enable = 1'b1;
        level_win      = '0;
        level_lose     = '0;

        step(2);
        expect_out(SEL_LRST, "rst_lrst", 32'h0);
        expect_out(SEL_LVL,  "rst_level", 32'h0);
        expect_out(SEL_LEDS, "rst_leds", leds_of(1'b0, 1'b0, LF, 4'd0));
        expect_out(SEL_RGB,  "rst_rgb", 32'h00F);
        score();
        reset = 1'b1;

        start_button = 1'b1;
        step(1);
        expect_out(SEL_RGB, "sync_e1_idle", 32'h00F);
        score();
        step(1);
        expect_out(SEL_RGB, "sync_e2_idle", 32'h00F);
        score();
        step(1);
        start_button = 1'b0;
        expect_out(SEL_LRST, "load_c1", 32'h0);
        expect_out(SEL_RGB,  "load_not_title", 32'h000);
        score();
        step(1);
        expect_out(SEL_LRST, "load_c2", 32'h0);
        score();
        step(1);
        expect_out(SEL_LRST, "play0_lrst", 32'h1);
        expect_out(SEL_LVL,  "play0_level", 32'h0);
        expect_out(SEL_RGB,  "play0_rgb", 32'hA14);
        score();
        display_enable = 1'b0;
        #1;
        expect_out(SEL_RGB, "play0_blank", 32'h000);
        score();
        display_enable = 1'b1;

        step(1);
        level_win = 3'b001;
        step(1);
        expect_out(SEL_LRST, "arm_ignore_c3", 32'h1);
        score();
        step(2);
        expect_out(SEL_LRST, "arm_ignore_c5", 32'h1);
        score();
        step(1);
        level_win = '0;
        expect_out(SEL_LRST, "win0_enter_lrst", 32'h0);
        expect_out(SEL_RGB,  "win0_enter_rgb", 32'h0F0);
        score();
        step(BC - 1);
        expect_out(SEL_RGB, "win0_last_cycle", 32'h0F0);
        expect_out(SEL_LVL, "win0_level_held", 32'h0);
        score();
        step(1);
        expect_out(SEL_LVL,  "win0_next_level", 32'h1);
        expect_out(SEL_LEDS, "win0_next_leds", leds_of(1'b0, 1'b0, LF, 4'd1));
        expect_out(SEL_LRST, "win0_next_load", 32'h0);
        score();

        step(2);
        expect_out(SEL_LRST, "play1_lrst", 32'h2);
        expect_out(SEL_RGB,  "play1_rgb", 32'hB25);
        score();
        step(4);
        level_win  = 3'b001;
        level_lose = 3'b100;
        step(1);
        expect_out(SEL_LRST, "other_flags_ignored", 32'h2);
        score();
        level_win  = 3'b010;
        level_lose = 3'b010;
        step(1);
        level_win  = '0;
        level_lose = '0;
        expect_out(SEL_RGB, "both_flags_win", 32'h0F0);
        score();
        step(BC);
        expect_out(SEL_LVL, "win1_next_level", 32'h2);
        score();

        start_button = 1'b1;
        step(2);
        expect_out(SEL_LRST, "play2_lrst", 32'h4);
        expect_out(SEL_RGB,  "play2_rgb", 32'hC36);
        score();
        step(1);
        start_button = 1'b0;
        step(3);
        expect_out(SEL_LRST, "start_ignored_in_play", 32'h4);
        score();
        level_win = 3'b100;
        step(1);
        level_win = '0;
        step(BC);
        expect_out(SEL_LEDS, "victory_leds", leds_of(1'b0, 1'b1, LF, 4'd2));
        expect_out(SEL_RGB,  "victory_rgb", 32'h0F0);
        expect_out(SEL_LRST, "victory_lrst", 32'h0);
        score();
        press_start();
        expect_out(SEL_LVL,  "victory_to_idle_level", 32'h0);
        expect_out(SEL_LEDS, "victory_to_idle_leds", leds_of(1'b0, 1'b0, LF, 4'd0));
        expect_out(SEL_RGB,  "victory_to_idle_rgb", 32'h00F);
        score();
        step(3);

        press_start();
        step(6);
        level_lose = 3'b001;
        step(1);
        level_lose = '0;
        expect_out(SEL_RGB, "lose_enter_rgb", 32'hF00);
        score();
`ifdef LEVEL_SEQ_LIVES_EN
        step(BC);
        expect_out(SEL_LEDS, "lives_3_to_2", leds_of(1'b0, 1'b0, 4'd2, 4'd0));
        score();
        step(6);
        level_lose = 3'b001;
        step(1);
        level_lose = '0;
        step(BC);
        expect_out(SEL_LEDS, "lives_2_to_1", leds_of(1'b0, 1'b0, 4'd1, 4'd0));
        score();
        step(6);
        level_lose = 3'b001;
        step(1);
        level_lose = '0;
`endif
        step(BC);
        expect_out(SEL_LEDS, "game_over_leds", leds_of(1'b1, 1'b0, 4'd0, 4'd0));
        expect_out(SEL_LRST, "game_over_lrst", 32'h0);
        expect_out(SEL_RGB,  "game_over_red", 32'hF00);
        score();
        display_enable = 1'b0;
        #1;
        expect_out(SEL_RGB, "game_over_blank", 32'h000);
        score();
        display_enable = 1'b1;
        press_start();
        expect_out(SEL_LEDS, "game_over_to_idle", leds_of(1'b0, 1'b0, LF, 4'd0));
        score();
        step(3);

        press_start();
`ifdef LEVEL_SEQ_LIVES_EN
        step(6);
        level_lose = 3'b001;
        step(1);
        level_lose = '0;
        step(BC);
        expect_out(SEL_LEDS, "pre_reset_lives_2", leds_of(1'b0, 1'b0, 4'd2, 4'd0));
        score();
`endif
        step(6);
        level_lose = 3'b001;
        step(1);
        level_lose = '0;
        step(3);
        expect_out(SEL_RGB, "mid_banner_red", 32'hF00);
        score();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        expect_out(SEL_RGB,  "banner_reset_idle", 32'h00F);
        expect_out(SEL_LEDS, "banner_reset_lives", leds_of(1'b0, 1'b0, LF, 4'd0));
        expect_out(SEL_LRST, "banner_reset_lrst", 32'h0);
        score();

        step(2);
        press_start();
        step(2);
        expect_out(SEL_LRST, "replay_lrst", 32'h1);
        score();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        expect_out(SEL_LRST, "play_reset_lrst", 32'h0);
        expect_out(SEL_RGB,  "play_reset_idle", 32'h00F);
        score();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
